// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller and its datapath:
// state enum, opcodes, operand/result select codes and the decoded control bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JALR   = 4'd10,
    S_JAL    = 4'd11,
    S_LUI    = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUA_PC    = 2'd0;
  localparam logic [1:0] ALUA_OLDPC = 2'd1;
  localparam logic [1:0] ALUA_RS1   = 2'd2;
  localparam logic [1:0] ALUA_ZERO  = 2'd3;

  localparam logic [1:0] ALUB_RS2  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [1:0] ALUB_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic [1:0] res_src;
    logic       retire;
  } ctrl_t;

  function automatic state_e decode_next(input logic [6:0] op);
    state_e nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_R:              nxt = S_EXECR;
      OP_I:              nxt = S_EXECI;
      OP_BRANCH:         nxt = S_BRANCH;
      OP_JAL:            nxt = S_JAL;
      OP_JALR:           nxt = S_JALR;
      OP_LUI:            nxt = S_LUI;
      OP_AUIPC:          nxt = S_ALUWB;
      default:           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_dec.sv
// Combinational state-to-control decoder. Everything is Moore except the
// mem_ready-qualified strobes and pc_we in BRANCH, which follows br_cond.
module ctrl_out_dec
  import multicycle_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready,
  input  logic   br_cond,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_a_sel = ALUA_PC;
        ctrl_o.alu_b_sel = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.res_src   = RES_ALU;
        ctrl_o.ir_we     = mem_ready;
        ctrl_o.pc_we     = mem_ready;
      end
      S_DECODE: begin
        ctrl_o.alu_a_sel = ALUA_OLDPC;
        ctrl_o.alu_b_sel = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_JALR: begin
        ctrl_o.alu_a_sel = ALUA_RS1;
        ctrl_o.alu_b_sel = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.res_src = RES_MEM;
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.retire  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.adr_src = 1'b1;
        ctrl_o.retire  = mem_ready;
      end
      S_EXECR: begin
        ctrl_o.alu_a_sel = ALUA_RS1;
        ctrl_o.alu_b_sel = ALUB_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_a_sel = ALUA_RS1;
        ctrl_o.alu_b_sel = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.res_src = RES_ALUOUT;
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.retire  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_a_sel = ALUA_RS1;
        ctrl_o.alu_b_sel = ALUB_RS2;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.res_src   = RES_ALUOUT;
        ctrl_o.pc_we     = br_cond;
        ctrl_o.retire    = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_a_sel = ALUA_OLDPC;
        ctrl_o.alu_b_sel = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.res_src   = RES_ALUOUT;
        ctrl_o.pc_we     = 1'b1;
      end
      S_LUI: begin
        ctrl_o.alu_a_sel = ALUA_ZERO;
        ctrl_o.alu_b_sel = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: state register, sticky illegal flag and the
// retired-instruction counter. Output decoding lives in ctrl_out_dec.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  alu_op,
  output logic [1:0]  res_src,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state_o
);

  // Memory handshake: mem_req is held with adr_src/mem_we stable while the FSM
  // sits in FETCH/MEMRD/MEMWR; the transfer completes in the cycle mem_ready=1.
  // mem_ready in any other state has no effect.
  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  ctrl_t       ctrl;

  ctrl_out_dec u_dec (
    .state_i   (state_q),
    .mem_ready (mem_ready),
    .br_cond   (br_cond),
    .ctrl_o    (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(opcode);
      S_MEMADR: state_d = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JALR:   state_d = S_JAL;
      S_JAL:    state_d = S_ALUWB;
      S_LUI:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q + {31'd0, ctrl.retire};
    // Set on the edge that enters TRAP so illegal is already high there.
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc_we     = ctrl.pc_we;
  assign ir_we     = ctrl.ir_we;
  assign reg_we    = ctrl.reg_we;
  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign adr_src   = ctrl.adr_src;
  assign alu_a_sel = ctrl.alu_a_sel;
  assign alu_b_sel = ctrl.alu_b_sel;
  assign alu_op    = ctrl.alu_op;
  assign res_src   = ctrl.res_src;
  assign illegal   = illegal_q;
  assign instret   = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued by
// the driver and compared by a negedge monitor.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int W = 51;

  // {pc_we,ir_we,reg_we,mem_req,mem_we,adr_src}, {alu_a,alu_b,alu_op,res_src}
  localparam logic [13:0] O_FETCH_WAIT = {6'b000100, 8'h22};
  localparam logic [13:0] O_FETCH_RDY  = {6'b110100, 8'h22};
  localparam logic [13:0] O_DECODE     = {6'b000000, 8'h50};
  localparam logic [13:0] O_MEMADR     = {6'b000000, 8'h90};
  localparam logic [13:0] O_MEMRD      = {6'b000101, 8'h00};
  localparam logic [13:0] O_MEMWB      = {6'b001000, 8'h01};
  localparam logic [13:0] O_MEMWR      = {6'b000111, 8'h00};
  localparam logic [13:0] O_EXECR      = {6'b000000, 8'h88};
  localparam logic [13:0] O_EXECI      = {6'b000000, 8'h98};
  localparam logic [13:0] O_ALUWB      = {6'b001000, 8'h00};
  localparam logic [13:0] O_BR0        = {6'b000000, 8'h84};
  localparam logic [13:0] O_BR1        = {6'b100000, 8'h84};
  localparam logic [13:0] O_JALR       = {6'b000000, 8'h90};
  localparam logic [13:0] O_JAL        = {6'b100000, 8'h60};
  localparam logic [13:0] O_LUI        = {6'b000000, 8'hD0};
  localparam logic [13:0] O_TRAP       = {6'b000000, 8'h00};

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_cond;
  logic        mem_ready;
  logic        pc_we, ir_we, reg_we, mem_req, mem_we, adr_src;
  logic [1:0]  alu_a_sel, alu_b_sel, alu_op, res_src;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .br_cond   (br_cond),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .adr_src   (adr_src),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .res_src   (res_src),
    .illegal   (illegal),
    .instret   (instret),
    .state_o   (state_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one call drives one cycle and queues that cycle's expected outputs
  task automatic step(input logic r, input logic [6:0] op, input logic mr,
                      input logic bc, input state_e s, input logic [13:0] o,
                      input logic il, input logic [31:0] ir, input string nm);
    @(posedge clk);
    #1;
    rst_n     = r;
    opcode    = op;
    mem_ready = mr;
    br_cond   = bc;
    exp_q.push_back({s, o, il, ir});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] obs;
      string        nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      obs = {state_o, pc_we, ir_we, reg_we, mem_req, mem_we, adr_src,
             alu_a_sel, alu_b_sel, alu_op, res_src, illegal, instret};
      n_checks++;
      if (obs === e) n_pass++;
      else $display("FAIL %s: got state=%0d ctl=%h ill=%b instret=%h, need state=%0d ctl=%h ill=%b instret=%h",
                    nm, obs[50:47], obs[46:33], obs[32], obs[31:0],
                    e[50:47], e[46:33], e[32], e[31:0]);
    end
  end

  initial begin
    rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0; br_cond = 1'b0;
    repeat (2) @(posedge clk);

    // reset holds FETCH decode, no retire
    step(0, OP_R, 0, 0, S_FETCH, O_FETCH_WAIT, 0, 0, "reset_hold");
    // R-type, zero-wait
    step(1, OP_R, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 0, "r_fetch");
    step(1, OP_R, 1, 0, S_DECODE, O_DECODE,    0, 0, "r_decode");
    step(1, OP_R, 1, 0, S_EXECR,  O_EXECR,     0, 0, "r_exec");
    step(1, OP_R, 1, 0, S_ALUWB,  O_ALUWB,     0, 0, "r_aluwb");
    // load, three wait cycles in MEMRD
    step(1, OP_LOAD, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 1, "ld_fetch");
    step(1, OP_LOAD, 1, 0, S_DECODE, O_DECODE,    0, 1, "ld_decode");
    step(1, OP_LOAD, 1, 0, S_MEMADR, O_MEMADR,    0, 1, "ld_memadr");
    step(1, OP_LOAD, 0, 0, S_MEMRD,  O_MEMRD,     0, 1, "ld_wait1");
    step(1, OP_LOAD, 0, 0, S_MEMRD,  O_MEMRD,     0, 1, "ld_wait2");
    step(1, OP_LOAD, 0, 0, S_MEMRD,  O_MEMRD,     0, 1, "ld_wait3");
    step(1, OP_LOAD, 1, 0, S_MEMRD,  O_MEMRD,     0, 1, "ld_ready");
    step(1, OP_LOAD, 1, 0, S_MEMWB,  O_MEMWB,     0, 1, "ld_memwb");
    // branch not taken, then taken
    step(1, OP_BRANCH, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 2, "bn_fetch");
    step(1, OP_BRANCH, 1, 0, S_DECODE, O_DECODE,    0, 2, "bn_decode");
    step(1, OP_BRANCH, 1, 0, S_BRANCH, O_BR0,       0, 2, "bn_branch");
    step(1, OP_BRANCH, 1, 1, S_FETCH,  O_FETCH_RDY, 0, 3, "bt_fetch");
    step(1, OP_BRANCH, 1, 1, S_DECODE, O_DECODE,    0, 3, "bt_decode");
    step(1, OP_BRANCH, 1, 1, S_BRANCH, O_BR1,       0, 3, "bt_branch");
    // I-type
    step(1, OP_I, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 4, "i_fetch");
    step(1, OP_I, 1, 0, S_DECODE, O_DECODE,    0, 4, "i_decode");
    step(1, OP_I, 1, 0, S_EXECI,  O_EXECI,     0, 4, "i_exec");
    step(1, OP_I, 1, 0, S_ALUWB,  O_ALUWB,     0, 4, "i_aluwb");
    // LUI
    step(1, OP_LUI, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 5, "lui_fetch");
    step(1, OP_LUI, 1, 0, S_DECODE, O_DECODE,    0, 5, "lui_decode");
    step(1, OP_LUI, 1, 0, S_LUI,    O_LUI,       0, 5, "lui_lui");
    step(1, OP_LUI, 1, 0, S_ALUWB,  O_ALUWB,     0, 5, "lui_aluwb");
    // JALR
    step(1, OP_JALR, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 6, "jalr_fetch");
    step(1, OP_JALR, 1, 0, S_DECODE, O_DECODE,    0, 6, "jalr_decode");
    step(1, OP_JALR, 1, 0, S_JALR,   O_JALR,      0, 6, "jalr_jalr");
    step(1, OP_JALR, 1, 0, S_JAL,    O_JAL,       0, 6, "jalr_jal");
    step(1, OP_JALR, 1, 0, S_ALUWB,  O_ALUWB,     0, 6, "jalr_aluwb");
    // JAL
    step(1, OP_JAL, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 7, "jal_fetch");
    step(1, OP_JAL, 1, 0, S_DECODE, O_DECODE,    0, 7, "jal_decode");
    step(1, OP_JAL, 1, 0, S_JAL,    O_JAL,       0, 7, "jal_jal");
    step(1, OP_JAL, 1, 0, S_ALUWB,  O_ALUWB,     0, 7, "jal_aluwb");
    // store, one wait cycle
    step(1, OP_STORE, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 8, "st_fetch");
    step(1, OP_STORE, 1, 0, S_DECODE, O_DECODE,    0, 8, "st_decode");
    step(1, OP_STORE, 1, 0, S_MEMADR, O_MEMADR,    0, 8, "st_memadr");
    step(1, OP_STORE, 0, 0, S_MEMWR,  O_MEMWR,     0, 8, "st_wait");
    step(1, OP_STORE, 1, 0, S_MEMWR,  O_MEMWR,     0, 8, "st_ready");
    // illegal opcode, stray mem_ready in TRAP, then reset out of TRAP
    step(1, 7'b0000000, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 9, "ill_fetch");
    step(1, 7'b0000000, 1, 0, S_DECODE, O_DECODE,    0, 9, "ill_decode");
    step(1, 7'b0000000, 1, 1, S_TRAP,   O_TRAP,      1, 9, "ill_trap1");
    step(1, 7'b0000000, 1, 1, S_TRAP,   O_TRAP,      1, 9, "ill_trap2");
    step(0, 7'b0000000, 0, 0, S_TRAP,   O_TRAP,      1, 9, "ill_rst_edge");
    // reset during a MEMWR wait
    step(1, OP_STORE, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 0, "rw_fetch");
    step(1, OP_STORE, 1, 0, S_DECODE, O_DECODE,    0, 0, "rw_decode");
    step(1, OP_STORE, 1, 0, S_MEMADR, O_MEMADR,    0, 0, "rw_memadr");
    step(1, OP_STORE, 0, 0, S_MEMWR,  O_MEMWR,     0, 0, "rw_wait");
    step(0, OP_STORE, 1, 0, S_MEMWR,  O_MEMWR,     0, 0, "rw_rst_edge");
    step(1, OP_STORE, 0, 0, S_FETCH,  O_FETCH_WAIT, 0, 0, "rw_after_rst");
    // instret wrap: preload all-ones, retire one store
    step(1, OP_STORE, 0, 0, S_FETCH, O_FETCH_WAIT, 0, 32'hFFFF_FFFF, "wrap_preload");
    #1 force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    step(1, OP_STORE, 1, 0, S_FETCH,  O_FETCH_RDY, 0, 32'hFFFF_FFFF, "wrap_fetch");
    step(1, OP_STORE, 1, 0, S_DECODE, O_DECODE,    0, 32'hFFFF_FFFF, "wrap_decode");
    step(1, OP_STORE, 1, 0, S_MEMADR, O_MEMADR,    0, 32'hFFFF_FFFF, "wrap_memadr");
    step(1, OP_STORE, 1, 0, S_MEMWR,  O_MEMWR,     0, 32'hFFFF_FFFF, "wrap_memwr");
    step(1, OP_STORE, 0, 0, S_FETCH,  O_FETCH_WAIT, 0, 32'h0000_0000, "wrap_result");

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, need 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
